tvip_axi_read_burst_responder: RTL and testbench
================================================

Name: tvip_axi_read_burst_responder

Overview:
- Subordinate-side AXI4 read responder: accepts one AR request, decodes the packed arlen/arsize/arburst fields into per-beat addresses, and issues single-beat reads to a simple fixed-latency memory port.
- Returns the data as R beats with rid, rresp and rlast.
- Sits between the AXI read channels and a local memory model or RAM, in the reverse direction of the initiator-side burst packing.

Parameters:
ID_WIDTH, 4, width of arid/rid
ADDRESS_WIDTH, 32, width of araddr/mem_address
DATA_WIDTH, 32, width of rdata/mem_read_data; power of two, 8..1024

Ports:
aclk  input  1  clock
areset  input  1  reset, asynchronous, active-high
arvalid  input  1  AR valid
arready  output  1  AR ready
arid  input  ID_WIDTH  AR id
araddr  input  ADDRESS_WIDTH  start address
arlen  input  8  burst length minus 1
arsize  input  3  log2 bytes per beat
arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
rvalid  output  1  R valid
rready  input  1  R ready
rid  output  ID_WIDTH  R id
rdata  output  DATA_WIDTH  R data
rresp  output  2  00 OKAY, 10 SLVERR
rlast  output  1  last beat
mem_read  output  1  memory read strobe
mem_address  output  ADDRESS_WIDTH  beat address
mem_read_data  input  DATA_WIDTH  valid exactly 1 cycle after mem_read

Behaviour:
- Clock and reset: one clock aclk; reset areset is asynchronous, active-high.
- Reset values: all outputs 0; internal state IDLE; 2-entry R FIFO emptied; in-flight flag cleared.
- arready: registered. It rises at the first aclk edge after areset deasserts and is high only in IDLE.
- State IDLE:
  - On arvalid&&arready, latch id, address, beat count = arlen+1, size, burst type, and error flag.
  - Go to BURST; arready drops the same edge.
- Error flag is set when any of these holds:
  - arburst==11;
  - 2^arsize > DATA_WIDTH/8;
  - WRAP with arlen not in {1,3,7,15}.
- State BURST: a beat is issued in a cycle when (fifo_count + inflight - pop) < 2, where pop = rvalid&&rready.
  - Issue (no error): mem_read=1, mem_address=current address.
  - Issue (error): mem_read stays 0; the slot still occupies the pipeline and carries rdata=0, rresp=10.
  - Normal beats: rresp=00.
  - Issue of the last beat returns the block to IDLE; arready is high the next cycle.
  - There is no overlap between bursts.
- Address sequencing, with S = 2^arsize and arithmetic modulo 2^ADDRESS_WIDTH:
  - FIXED: address is constant.
  - INCR: next = (addr & ~(S-1)) + S. The first beat may be unaligned; later beats are aligned.
  - WRAP: boundary = addr & ~(S*(arlen+1)-1). next = addr+S; if next == boundary + S*(arlen+1), next = boundary.
  - No 4KB-crossing check.
- Data path: mem_read_data (or zero for error beats) is written to the FIFO at the edge one cycle after issue. The FIFO head drives rvalid/rid/rdata/rresp/rlast. rlast is set on the final beat only.
- Latency:
  - AR handshake at edge E0 → mem_read in cycle E0..E1 → rvalid visible after E2 (2 cycles).
  - Throughput is 1 beat/cycle while rready=1.
- Backpressure: while rvalid&&!rready, R outputs hold stable. Issue stalls once 2 beats are buffered or in flight, so no data is lost.
- Reset mid-burst: everything returns to reset values immediately; in-flight data is discarded, and mem_read_data is ignored for one cycle after reset release.

Optional Feature:
TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
- Defined: adds a 1-entry AR holding register.
  - arready is high whenever that register is empty, including during BURST.
  - A buffered request starts in the cycle after the current burst's last issue, giving back-to-back bursts with no idle cycle on mem_read.
  - The register is cleared by reset.
- Undefined: arready is high only in IDLE, as described above.

Test Plan:
- INCR arid=5, araddr=0x1000, arlen=3, arsize=2 (DATA_WIDTH 32), rready=1 → mem_address 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; 4 beats with rid=5, rresp=00, rlast on beat 4 only; first rvalid 2 cycles after the AR handshake.
- WRAP araddr=0x1008, arlen=3, arsize=2 → addresses 0x1008, 0x100C, 0x1000, 0x1004.
- FIXED araddr=0x2003, arlen=1 → 0x2003 twice.
- INCR araddr=0x1002, arsize=2, arlen=2 → 0x1002, 0x1004, 0x1008.
- arlen=7 with rready low for 5 cycles after beat 2 → mem_read stalls at most 2 beats beyond consumed; rdata/rlast stable while stalled; 8 correct beats delivered.
- arburst=11, arlen=1 → 2 beats with rdata=0 and rresp=10, mem_read never asserted.
- arsize=3 with DATA_WIDTH 32 → all beats rresp=10.
- Assert areset during beat 2 of an arlen=7 burst → all outputs 0 while reset is held; arready=1 at the first edge after release; a following INCR burst completes with correct addresses and data.

Source files
------------

// File: rtl/tvip_axi_read_burst_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : tvip_axi_read_burst_responder_if
// Brief   : AXI4 AR/R channel bundle between a read initiator and a responder.
// Revision: 1.0
// ============================================================================
interface tvip_axi_read_burst_responder_if #(
    parameter int ID_WIDTH      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     arvalid;
    logic                     arready;
    logic [ID_WIDTH-1:0]      arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     rvalid;
    logic                     rready;
    logic [ID_WIDTH-1:0]      rid;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface
`default_nettype wire

// File: rtl/tvip_axi_read_burst_responder.sv
`default_nettype none
// ============================================================================
// Module  : tvip_axi_read_burst_responder
// Brief   : AXI4 read responder; expands AR bursts into single-beat reads of a
//           1-cycle-latency memory and returns R beats through a 2-entry FIFO.
//           Define TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN for a 1-entry AR
//           holding register that allows back-to-back bursts.
// Revision: 1.0
// ============================================================================
module tvip_axi_read_burst_responder #(
    parameter int ID_WIDTH      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  wire logic                      aclk,
    input  wire logic                      areset,
    tvip_axi_read_burst_responder_if.slave axi,
    output logic                           mem_read,
    output logic [ADDRESS_WIDTH-1:0]       mem_address,
    input  wire logic [DATA_WIDTH-1:0]     mem_read_data
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                err;
    } req_t;

    state_t                   state, state_next;
    req_t                     req, ar_req;
    logic [ADDRESS_WIDTH-1:0] cur_addr, addr_next;
    logic [ADDRESS_WIDTH-1:0] beat_bytes, wrap_bytes, wrap_base, addr_plus;
    logic [7:0]               remaining;
    logic                     arready_q, arready_next;
    logic                     ar_hs, issue, last_issue, pop, load_ar;
    logic [1:0]               occupancy;

    logic                     inflight, inflight_err, inflight_last;
    logic [ID_WIDTH-1:0]      inflight_id;

    logic [1:0]               fifo_count;
    logic                     rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0]    fifo_data [2];
    logic [1:0]               fifo_resp [2];
    logic                     fifo_last [2];
    logic [ID_WIDTH-1:0]      fifo_id   [2];

`ifdef TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
    req_t                     buf_req;
    logic [ADDRESS_WIDTH-1:0] buf_addr;
    logic                     buf_valid, buf_next, load_buf, start_buf;
`endif

    assign ar_hs      = axi.arvalid && arready_q;
    assign pop        = (fifo_count != 2'd0) && axi.rready;
    // Buffered beats plus the one in flight, after this cycle's pop, must leave room.
    assign occupancy  = fifo_count + 2'(inflight) - 2'(pop);
    assign issue      = (state == BURST) && (occupancy < 2'd2);
    assign last_issue = issue && (remaining == 8'd0);

    assign mem_read    = issue && !req.err;
    assign mem_address = mem_read ? cur_addr : '0;

    assign axi.arready = arready_q;
    assign axi.rvalid  = (fifo_count != 2'd0);
    assign axi.rid     = fifo_id[rd_ptr];
    assign axi.rdata   = fifo_data[rd_ptr];
    assign axi.rresp   = fifo_resp[rd_ptr];
    assign axi.rlast   = fifo_last[rd_ptr];

    always_comb begin
        ar_req.id    = axi.arid;
        ar_req.len   = axi.arlen;
        ar_req.size  = axi.arsize;
        ar_req.burst = axi.arburst;
        ar_req.err   = (axi.arburst == 2'b11)
                    || (axi.arsize > 3'(MAX_SIZE))
                    || ((axi.arburst == 2'b10)
                        && !(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

    always_comb begin
        beat_bytes = ADDRESS_WIDTH'(1) << req.size;
        wrap_bytes = ADDRESS_WIDTH'({1'b0, req.len} + 9'd1) << req.size;
        wrap_base  = cur_addr & ~(wrap_bytes - ADDRESS_WIDTH'(1));
        addr_plus  = cur_addr + beat_bytes;
        case (req.burst)
            2'b01:   addr_next = (cur_addr & ~(beat_bytes - ADDRESS_WIDTH'(1))) + beat_bytes;
            2'b10:   addr_next = (addr_plus == wrap_base + wrap_bytes) ? wrap_base : addr_plus;
            default: addr_next = cur_addr;
        endcase
    end

    always_comb begin
        state_next = state;
        load_ar    = 1'b0;
`ifdef TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
        load_buf   = 1'b0;
        start_buf  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    load_ar    = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (last_issue) begin
`ifdef TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
                    if (buf_valid)  start_buf  = 1'b1;
                    else if (ar_hs) load_ar    = 1'b1;
                    else            state_next = IDLE;
`else
                    state_next = IDLE;
`endif
                end
`ifdef TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
                else if (ar_hs) begin
                    load_buf = 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
`ifdef TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
        buf_next     = load_buf || (buf_valid && !start_buf);
        arready_next = !buf_next;
`else
        arready_next = (state_next == IDLE);
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arready_q     <= 1'b0;
            req           <= '0;
            cur_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_err  <= 1'b0;
            inflight_last <= 1'b0;
            inflight_id   <= '0;
        end else begin
            arready_q <= arready_next;
            if (load_ar) begin
                req       <= ar_req;
                cur_addr  <= axi.araddr;
                remaining <= axi.arlen;
            end
`ifdef TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
            else if (start_buf) begin
                req       <= buf_req;
                cur_addr  <= buf_addr;
                remaining <= buf_req.len;
            end
`endif
            else if (issue) begin
                cur_addr  <= addr_next;
                remaining <= remaining - 8'd1;
            end
            inflight      <= issue;
            inflight_err  <= req.err;
            inflight_last <= (remaining == 8'd0);
            inflight_id   <= req.id;
        end
    end

`ifdef TVIP_AXI_READ_RESPONDER_AR_BUFFER_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            buf_valid <= 1'b0;
            buf_req   <= '0;
            buf_addr  <= '0;
        end else begin
            buf_valid <= buf_next;
            if (load_buf) begin
                buf_req  <= ar_req;
                buf_addr <= axi.araddr;
            end
        end
    end
`endif

    // Memory data is valid the cycle after issue; error beats substitute zero.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            fifo_count <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_resp[i] <= 2'b00;
                fifo_last[i] <= 1'b0;
                fifo_id[i]   <= '0;
            end
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= inflight_err ? '0 : mem_read_data;
                fifo_resp[wr_ptr] <= inflight_err ? 2'b10 : 2'b00;
                fifo_last[wr_ptr] <= inflight_last;
                fifo_id[wr_ptr]   <= inflight_id;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + 2'(inflight) - 2'(pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tvip_axi_read_burst_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_tvip_axi_read_burst_responder
// Brief   : Directed self-checking bench for the AXI read burst responder.
// Revision: 1.0
// ============================================================================
module tb_tvip_axi_read_burst_responder;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tvip_axi_read_burst_responder_if #(.ID_WIDTH(IW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_read_data = '0;

    tvip_axi_read_burst_responder #(.ID_WIDTH(IW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk          (clk),
        .areset        (rst),
        .axi           (axi),
        .mem_read      (mem_read),
        .mem_address   (mem_address),
        .mem_read_data (mem_read_data)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    logic [AW-1:0] addr_q[$];
    int            addr_cyc_q[$];
    beat_t         beat_q[$];
    int            beat_cyc_q[$];

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle memory; idle cycles return a marker that error beats must not show.
    always @(posedge clk) mem_read_data <= mem_read ? mdata(mem_address) : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (mem_read) begin
            addr_q.push_back(mem_address);
            addr_cyc_q.push_back(cyc);
        end
        if (axi.rvalid && axi.rready) begin
            beat_q.push_back({axi.rid, axi.rdata, axi.rresp, axi.rlast});
            beat_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        addr_q.delete();
        addr_cyc_q.delete();
        beat_q.delete();
        beat_cyc_q.delete();
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int hs);
        int n = 0;
        axi.arvalid = 1'b1;
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        while (!axi.arready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_handshake: arready=%b, required 1 within 50 cycles", axi.arready);
        end
        @(posedge clk); #1;
        hs          = cyc;
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_q.size() < n && k < 200) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (beat_q.size() < n) begin
            errors++;
            $display("FAIL beat_count: got %0d beats, required %0d", beat_q.size(), n);
        end
    endtask

    task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output int hs);
        clear_logs();
        axi.rready = 1'b1;
        send_ar(id, addr, len, size, burst, hs);
        wait_beats(int'(len) + 1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({axi.arready, axi.rvalid, axi.rid, axi.rdata, axi.rresp, axi.rlast, mem_read, mem_address} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: arready=%b rvalid=%b rdata=%h mem_read=%b, required all 0",
                     axi.arready, axi.rvalid, axi.rdata, mem_read);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (axi.arready !== 1'b0) begin
            errors++;
            $display("FAIL arready_before_edge: arready=%b, required 0", axi.arready);
        end
        @(posedge clk); #1;
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL arready_after_release: arready=%b, required 1", axi.arready);
        end
    endtask

    task automatic test_incr();
        logic [AW-1:0] exp [4];
        int hs;
        exp = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        do_burst(4'd5, 32'h1000, 8'd3, 3'd2, 2'b01, hs);
        checks++;
        if (addr_q.size() != 4) begin
            errors++;
            $display("FAIL incr_reads: %0d mem reads, required 4", addr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_q[i] !== exp[i] || addr_cyc_q[i] != hs + i) begin
                errors++;
                $display("FAIL incr_addr[%0d]: %h at cycle %0d, required %h at cycle %0d",
                         i, addr_q[i], addr_cyc_q[i], exp[i], hs + i);
            end
            checks++;
            if (beat_q[i] !== {4'd5, mdata(exp[i]), 2'b00, (i == 3)}) begin
                errors++;
                $display("FAIL incr_beat[%0d]: got %h, required %h", i, beat_q[i],
                         {4'd5, mdata(exp[i]), 2'b00, (i == 3)});
            end
        end
        checks++;
        if (beat_cyc_q[0] != hs + 2) begin
            errors++;
            $display("FAIL incr_latency: first rvalid at cycle %0d, required %0d", beat_cyc_q[0], hs + 2);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp [4];
        int hs;
        exp = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        do_burst(4'd9, 32'h1008, 8'd3, 3'd2, 2'b10, hs);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_q[i] !== exp[i] || beat_q[i] !== {4'd9, mdata(exp[i]), 2'b00, (i == 3)}) begin
                errors++;
                $display("FAIL wrap[%0d]: addr %h beat %h, required addr %h data %h",
                         i, addr_q[i], beat_q[i], exp[i], mdata(exp[i]));
            end
        end
    endtask

    task automatic test_fixed();
        int hs;
        do_burst(4'd1, 32'h2003, 8'd1, 3'd2, 2'b00, hs);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (addr_q[i] !== 32'h2003 || beat_q[i] !== {4'd1, mdata(32'h2003), 2'b00, (i == 1)}) begin
                errors++;
                $display("FAIL fixed[%0d]: addr %h beat %h, required addr 2003", i, addr_q[i], beat_q[i]);
            end
        end
    endtask

    task automatic test_incr_unaligned();
        logic [AW-1:0] exp [3];
        int hs;
        exp = '{32'h1002, 32'h1004, 32'h1008};
        do_burst(4'd3, 32'h1002, 8'd2, 3'd2, 2'b01, hs);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_q[i] !== exp[i] || beat_q[i] !== {4'd3, mdata(exp[i]), 2'b00, (i == 2)}) begin
                errors++;
                $display("FAIL unaligned[%0d]: addr %h beat %h, required addr %h", i, addr_q[i], beat_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int    hs;
        int    k = 0;
        beat_t held;
        clear_logs();
        axi.rready = 1'b1;
        send_ar(4'd2, 32'h3000, 8'd7, 3'd2, 2'b01, hs);
        while (beat_q.size() < 2 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        axi.rready = 1'b0;
        held = {4'd2, mdata(32'h3008), 2'b00, 1'b0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (axi.rvalid !== 1'b1 || {axi.rid, axi.rdata, axi.rresp, axi.rlast} !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d]: rvalid=%b r=%h, required rvalid=1 r=%h", c, axi.rvalid,
                         {axi.rid, axi.rdata, axi.rresp, axi.rlast}, held);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (addr_q.size() != 4) begin
            errors++;
            $display("FAIL stall_issue: %0d reads during stall, required 4", addr_q.size());
        end
        axi.rready = 1'b1;
        wait_beats(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (addr_q[i] !== 32'h3000 + 4 * i
                || beat_q[i] !== {4'd2, mdata(32'h3000 + 4 * i), 2'b00, (i == 7)}) begin
                errors++;
                $display("FAIL stall_beat[%0d]: addr %h beat %h, required addr %h", i, addr_q[i], beat_q[i],
                         32'h3000 + 4 * i);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reserved_burst();
        int hs;
        do_burst(4'd6, 32'h4000, 8'd1, 3'd2, 2'b11, hs);
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL reserved_mem_read: %0d reads, required 0", addr_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (beat_q[i] !== {4'd6, 32'h0, 2'b10, (i == 1)}) begin
                errors++;
                $display("FAIL reserved_beat[%0d]: got %h, required %h", i, beat_q[i], {4'd6, 32'h0, 2'b10, (i == 1)});
            end
        end
    endtask

    task automatic test_bad_size();
        int hs;
        do_burst(4'd4, 32'h5000, 8'd1, 3'd3, 2'b01, hs);
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL badsize_mem_read: %0d reads, required 0", addr_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (beat_q[i].resp !== 2'b10 || beat_q[i].data !== '0) begin
                errors++;
                $display("FAIL badsize_beat[%0d]: resp %b data %h, required resp 10 data 0", i, beat_q[i].resp,
                         beat_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int hs;
        int k = 0;
        clear_logs();
        axi.rready = 1'b1;
        send_ar(4'd7, 32'h6000, 8'd7, 3'd2, 2'b01, hs);
        while (beat_q.size() < 1 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({axi.arready, axi.rvalid, axi.rid, axi.rdata, axi.rresp, axi.rlast, mem_read, mem_address} !== '0) begin
                errors++;
                $display("FAIL midreset_outputs[%0d]: arready=%b rvalid=%b rdata=%h mem_read=%b, required all 0",
                         c, axi.arready, axi.rvalid, axi.rdata, mem_read);
            end
            @(posedge clk);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_arready: arready=%b, required 1", axi.arready);
        end
        do_burst(4'd3, 32'h7000, 8'd1, 3'd2, 2'b01, hs);
        checks++;
        if (addr_q.size() != 2) begin
            errors++;
            $display("FAIL post_reset_reads: %0d reads, required 2", addr_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (addr_q[i] !== 32'h7000 + 4 * i
                || beat_q[i] !== {4'd3, mdata(32'h7000 + 4 * i), 2'b00, (i == 1)}) begin
                errors++;
                $display("FAIL post_reset_beat[%0d]: addr %h beat %h, required addr %h", i, addr_q[i], beat_q[i],
                         32'h7000 + 4 * i);
            end
        end
    endtask

    initial begin
        axi.arvalid = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arsize  = '0;
        axi.arburst = '0;
        axi.rready  = 1'b0;
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_incr_unaligned();
        test_backpressure();
        test_reserved_burst();
        test_bad_size();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
